// File: rtl/sorting_network_pipelined_pkg.sv
// Shared constants, direction type and stage-pairing helper for the sorting network.
// Optional index tracking is enabled with the SORT_INDEX_TRACK_EN macro.
package sort_pkg;

  localparam int NUM_INPUTS_MIN = 2;
  localparam int NUM_INPUTS_MAX = 32;

  typedef enum logic {
    SORT_ASC  = 1'b0,
    SORT_DESC = 1'b1
  } sort_dir_t;

  // Even stages pair (0,1),(2,3)...; odd stages pair (1,2),(3,4)...
  function automatic int pair_offset(input int stage);
    return stage % 2;
  endfunction

endpackage

// File: rtl/sorting_network_pipelined_if.sv
// Stream interface of the sorting network: unsorted vectors in, sorted vectors out.
// m_index exists only when SORT_INDEX_TRACK_EN is defined.
interface sorting_network_pipelined_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 5
);
`ifdef SORT_INDEX_TRACK_EN
  localparam int IDX_W = $clog2(NUM_INPUTS);
`endif

  logic                             s_valid;
  logic                             s_ready;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_data;
  logic                             s_descending;
  logic                             m_valid;
  logic                             m_ready;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] m_data;
  logic [DATA_WIDTH-1:0]            m_median;
`ifdef SORT_INDEX_TRACK_EN
  logic [NUM_INPUTS*IDX_W-1:0]      m_index;
`endif

  modport master (
    output s_valid, s_data, s_descending, m_ready,
    input  s_ready, m_valid, m_data, m_median
`ifdef SORT_INDEX_TRACK_EN
    , input m_index
`endif
  );

  modport slave (
    input  s_valid, s_data, s_descending, m_ready,
    output s_ready, m_valid, m_data, m_median
`ifdef SORT_INDEX_TRACK_EN
    , output m_index
`endif
  );

endinterface

// File: rtl/sorting_network_pipelined_cmp_exchange_cell.sv
// Combinational compare-exchange of two elements with direction control.
// With SORT_INDEX_TRACK_EN defined, position tags follow their data through the swap.
module cmp_exchange_cell
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = 8
`ifdef SORT_INDEX_TRACK_EN
  , parameter int IDX_W = 3
`endif
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  sort_dir_t             dir,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] hi
`ifdef SORT_INDEX_TRACK_EN
  , input  logic [IDX_W-1:0]    a_idx
  , input  logic [IDX_W-1:0]    b_idx
  , output logic [IDX_W-1:0]    lo_idx
  , output logic [IDX_W-1:0]    hi_idx
`endif
);

  logic swap;

  // Strict comparison only, so equal elements never trade places (stable sort).
  always_comb begin
    swap = (dir == SORT_ASC) ? (a > b) : (a < b);
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end

`ifdef SORT_INDEX_TRACK_EN
  always_comb begin
    lo_idx = swap ? b_idx : a_idx;
    hi_idx = swap ? a_idx : b_idx;
  end
`endif

endmodule

// File: rtl/sorting_network_pipelined.sv
// Fully pipelined odd-even transposition sorter, NUM_INPUTS registered stages, global stall.
// Define SORT_INDEX_TRACK_EN to carry original input positions to m_index.
module sorting_network_pipelined
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 5
) (
  input  logic                    i_clk,
  input  logic                    i_aresetn,
  sorting_network_pipelined_if.slave bus
);

  if (NUM_INPUTS < NUM_INPUTS_MIN || NUM_INPUTS > NUM_INPUTS_MAX) begin : g_bad_num_inputs
    $error("sorting_network_pipelined: NUM_INPUTS=%0d outside 2..32", NUM_INPUTS);
  end

  typedef logic [DATA_WIDTH-1:0] elem_t;

  elem_t     stage_in  [NUM_INPUTS][NUM_INPUTS];
  elem_t     stage_out [NUM_INPUTS][NUM_INPUTS];
  elem_t     data_p    [NUM_INPUTS][NUM_INPUTS];
  sort_dir_t dir_in    [NUM_INPUTS];
  sort_dir_t dir_p     [NUM_INPUTS];
  logic      vld_p     [NUM_INPUTS];
  logic      stall;

`ifdef SORT_INDEX_TRACK_EN
  localparam int IDX_W = $clog2(NUM_INPUTS);
  typedef logic [IDX_W-1:0] idx_t;

  idx_t idx_in  [NUM_INPUTS][NUM_INPUTS];
  idx_t idx_out [NUM_INPUTS][NUM_INPUTS];
  idx_t idx_p   [NUM_INPUTS][NUM_INPUTS];
`endif

  assign stall       = vld_p[NUM_INPUTS-1] && !bus.m_ready;
  assign bus.s_ready = !stall;

  for (genvar s = 0; s < NUM_INPUTS; s++) begin : g_stage
    localparam int OFF = pair_offset(s);

    if (s == 0) begin : g_first
      assign dir_in[0] = sort_dir_t'(bus.s_descending);
      for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_src
        assign stage_in[0][k] = bus.s_data[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef SORT_INDEX_TRACK_EN
        assign idx_in[0][k]   = IDX_W'(k);
`endif
      end
    end else begin : g_next
      assign dir_in[s] = dir_p[s-1];
      for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_src
        assign stage_in[s][k] = data_p[s-1][k];
`ifdef SORT_INDEX_TRACK_EN
        assign idx_in[s][k]   = idx_p[s-1][k];
`endif
      end
    end

    // Lane k owns a cell when it is the lower member of a pair; the upper member is driven
    // by that cell; anything else is an unpaired edge lane and passes straight through.
    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_lane
      if (k >= OFF && ((k - OFF) % 2 == 0) && (k + 1 < NUM_INPUTS)) begin : g_pair
        cmp_exchange_cell #(
          .DATA_WIDTH (DATA_WIDTH)
`ifdef SORT_INDEX_TRACK_EN
          , .IDX_W    (IDX_W)
`endif
        ) u_cell (
          .a      (stage_in[s][k]),
          .b      (stage_in[s][k+1]),
          .dir    (dir_in[s]),
          .lo     (stage_out[s][k]),
          .hi     (stage_out[s][k+1])
`ifdef SORT_INDEX_TRACK_EN
          , .a_idx  (idx_in[s][k])
          , .b_idx  (idx_in[s][k+1])
          , .lo_idx (idx_out[s][k])
          , .hi_idx (idx_out[s][k+1])
`endif
        );
      end else if (!(k > OFF && ((k - OFF) % 2 == 1))) begin : g_pass
        assign stage_out[s][k] = stage_in[s][k];
`ifdef SORT_INDEX_TRACK_EN
        assign idx_out[s][k]   = idx_in[s][k];
`endif
      end
    end
  end

  // Stage registers: everything advances together unless the output is blocked.
  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        vld_p[i] <= 1'b0;
        dir_p[i] <= SORT_ASC;
        for (int j = 0; j < NUM_INPUTS; j++) begin
          data_p[i][j] <= '0;
`ifdef SORT_INDEX_TRACK_EN
          idx_p[i][j]  <= '0;
`endif
        end
      end
    end else if (!stall) begin
      vld_p[0] <= bus.s_valid;
      for (int i = 1; i < NUM_INPUTS; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
      for (int i = 0; i < NUM_INPUTS; i++) begin
        dir_p[i] <= dir_in[i];
        for (int j = 0; j < NUM_INPUTS; j++) begin
          data_p[i][j] <= stage_out[i][j];
`ifdef SORT_INDEX_TRACK_EN
          idx_p[i][j]  <= idx_out[i][j];
`endif
        end
      end
    end
  end

  assign bus.m_valid  = vld_p[NUM_INPUTS-1];
  assign bus.m_median = data_p[NUM_INPUTS-1][NUM_INPUTS/2];

  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_out
    assign bus.m_data[k*DATA_WIDTH +: DATA_WIDTH] = data_p[NUM_INPUTS-1][k];
`ifdef SORT_INDEX_TRACK_EN
    assign bus.m_index[k*IDX_W +: IDX_W]          = idx_p[NUM_INPUTS-1][k];
`endif
  end

endmodule

// File: tb/tb_sorting_network_pipelined.sv
// Scoreboard bench for sorting_network_pipelined (N=5, W=8); index checks when SORT_INDEX_TRACK_EN is defined.
module tb_sorting_network_pipelined;

  localparam int W  = 8;
  localparam int N  = 5;
  localparam int DW = N * W;
  localparam int XW = N * 3;

  typedef struct {
    logic [DW-1:0] data;
    logic [W-1:0]  med;
    logic [XW-1:0] idx;
    int            acc_cyc;
    int            lat;
  } exp_t;

  logic clk;
  logic rstn;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t mon_e;

  sorting_network_pipelined_if #(.DATA_WIDTH(W), .NUM_INPUTS(N)) bus ();

  sorting_network_pipelined #(.DATA_WIDTH(W), .NUM_INPUTS(N)) dut (
    .i_clk     (clk),
    .i_aresetn (rstn),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pk(input int e0, input int e1, input int e2, input int e3, input int e4);
    return {8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  function automatic logic [XW-1:0] pix(input int i0, input int i1, input int i2, input int i3, input int i4);
    return {3'(i4), 3'(i3), 3'(i2), 3'(i1), 3'(i0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    if (rstn === 1'b1 && bus.m_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got m_data=%0h, required no output", bus.m_data);
      end else begin
        mon_e = sb[0];
        chk("m_data", 64'(bus.m_data), 64'(mon_e.data));
        chk("m_median", 64'(bus.m_median), 64'(mon_e.med));
`ifdef SORT_INDEX_TRACK_EN
        chk("m_index", 64'(bus.m_index), 64'(mon_e.idx));
`endif
        if (bus.m_ready === 1'b1) begin
          if (mon_e.lat > 0) chk("latency", 64'(cyc - mon_e.acc_cyc), 64'(mon_e.lat));
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic desc, input logic [DW-1:0] ed,
                      input int emed, input logic [XW-1:0] eidx, input bit expect_out, input int lat);
    bit   acc;
    int   n;
    exp_t e;
    bus.s_valid      = 1'b1;
    bus.s_data       = d;
    bus.s_descending = desc;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = (bus.s_ready === 1'b1);
      if (acc && expect_out) begin
        e.data = ed; e.med = 8'(emed); e.idx = eidx; e.acc_cyc = cyc; e.lat = lat;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rstn             = 1'b0;
    bus.s_valid      = 1'b1;
    bus.s_data       = pk(1, 2, 3, 4, 5);
    bus.s_descending = 1'b0;
    bus.m_ready      = 1'b1;

    // Reset held three cycles with a valid input pending.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
      chk("rst_m_data", 64'(bus.m_data), 64'd0);
      chk("rst_m_median", 64'(bus.m_median), 64'd0);
      chk("rst_s_ready", 64'(bus.s_ready), 64'd1);
`ifdef SORT_INDEX_TRACK_EN
      chk("rst_m_index", 64'(bus.m_index), 64'd0);
`endif
    end
    rstn        = 1'b1;
    bus.s_valid = 1'b0;
    idle(8);

    // Basic ascending vector.
    send(pk(10, 5, 255, 100, 180), 1'b0, pk(5, 10, 100, 180, 255), 100, pix(1, 0, 3, 4, 2), 1, N);
    idle(1);
    drain();

    // Ascending then descending back to back.
    send(pk(10, 5, 255, 100, 180), 1'b0, pk(5, 10, 100, 180, 255), 100, pix(1, 0, 3, 4, 2), 1, N);
    send(pk(10, 5, 255, 100, 180), 1'b1, pk(255, 180, 100, 10, 5), 100, pix(2, 4, 3, 0, 1), 1, N);
    idle(1);
    drain();

    // Ties keep their original order in both directions.
    send(pk(180, 180, 7, 7, 0), 1'b0, pk(0, 7, 7, 180, 180), 7, pix(4, 2, 3, 0, 1), 1, N);
    send(pk(180, 180, 7, 7, 0), 1'b1, pk(180, 180, 7, 7, 0), 7, pix(0, 1, 2, 3, 4), 1, N);
    send(pk(77, 77, 77, 77, 77), 1'b0, pk(77, 77, 77, 77, 77), 77, pix(0, 1, 2, 3, 4), 1, N);
    idle(1);
    drain();
    idle(2);

    // Backpressure: two-cycle stall while the first of three vectors sits at the output.
    fork
      begin
        send(pk(1, 2, 3, 4, 5), 1'b1, pk(5, 4, 3, 2, 1), 3, pix(4, 3, 2, 1, 0), 1, 0);
        send(pk(0, 255, 0, 255, 128), 1'b0, pk(0, 0, 128, 255, 255), 128, pix(0, 2, 4, 1, 3), 1, 0);
        send(pk(9, 8, 7, 6, 5), 1'b0, pk(5, 6, 7, 8, 9), 7, pix(4, 3, 2, 1, 0), 1, 0);
        idle(3);
        send(pk(50, 40, 60, 30, 70), 1'b1, pk(70, 60, 50, 40, 30), 50, pix(4, 2, 0, 1, 3), 1, N);
        idle(1);
      end
      begin
        int n;
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (bus.m_valid !== 1'b1 && n < 30);
        chk("stall_first_out", 64'(bus.m_valid), 64'd1);
        bus.m_ready = 1'b0;
        @(negedge clk);
        chk("s_ready_stall1", 64'(bus.s_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("s_ready_stall2", 64'(bus.s_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk("s_ready_resume", 64'(bus.s_ready), 64'd1);
      end
    join
    drain();
    idle(2);

    // One-cycle reset with three vectors in flight: all discarded.
    send(pk(11, 22, 33, 44, 55), 1'b0, '0, 0, '0, 0, 0);
    send(pk(99, 88, 77, 66, 55), 1'b1, '0, 0, '0, 0, 0);
    send(pk(3, 1, 4, 1, 5), 1'b0, '0, 0, '0, 0, 0);
    bus.s_valid = 1'b0;
    rstn        = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("midrst_m_data", 64'(bus.m_data), 64'd0);
    chk("midrst_s_ready", 64'(bus.s_ready), 64'd1);
    @(posedge clk);
    #1;
    idle(1);
    send(pk(3, 200, 1, 200, 2), 1'b0, pk(1, 2, 3, 200, 200), 3, pix(2, 4, 0, 1, 3), 1, N);
    idle(10);
    drain();

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sorting_network_pipelined.md
# sorting_network_pipelined

- Parametrised, fully pipelined odd-even transposition sorting network over `NUM_INPUTS` unsigned words.
- Successor to the two-input registered compare-swap block: generalised in element count and sort direction, with a valid/ready stream handshake and backpressure stall.
- Feeds the median/rank-filter datapath: one unsorted vector in per cycle, one sorted vector plus its median element out per cycle after fixed latency.

## Interface
- `DATA_WIDTH`, 8: width of each element, unsigned.
- `NUM_INPUTS`, 5: elements per vector; legal range 2..32. Elaboration fails outside this range.
- `i_clk` in 1: clock, rising edge.
- `i_aresetn` in 1: reset, synchronous, active-low.
- `s_valid` in 1: input vector valid.
- `s_ready` out 1: input accepted when `s_valid && s_ready`.
- `s_data` in `NUM_INPUTS*DATA_WIDTH`: element k at `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `s_descending` in 1: direction for this vector (0 ascending, 1 descending). Sampled with the data.
- `m_valid` out 1: sorted vector valid.
- `m_ready` in 1: downstream ready.
- `m_data` out `NUM_INPUTS*DATA_WIDTH`: sorted vector. Element 0 is the smallest when ascending, the largest when descending.
- `m_median` out `DATA_WIDTH`: element `NUM_INPUTS/2` of `m_data` (integer division).
- `m_index` out `NUM_INPUTS*$clog2(NUM_INPUTS)`: only with `SORT_INDEX_TRACK_EN`. Entry k is the original input position of output element k.

## Operation
- `NUM_INPUTS` stages numbered s = 0..N-1. Every stage is registered.
- Even stages compare pairs (0,1),(2,3),… Odd stages compare pairs (1,2),(3,4),…
- An unpaired element passes through the stage register unchanged.
- Compare-exchange, ascending: the lower position receives `min`, the higher position receives `max`. Descending is the mirror.
- Swap only on strict inequality. Equal values keep their positions, so the sort is stable.
- The direction bit and a valid bit travel with each stage register. Vectors of mixed direction may be in flight at once.
- Global stall: `stall = m_valid && !m_ready`.
  - While `stall` is high, every stage register, valid bit and direction bit holds.
  - `s_ready = !stall`.
- A bubble (stage valid = 0) advances like data. Bubbles are not compressed.
- Reset (`!i_aresetn` at a clock edge):
  - All data, index, direction and valid registers clear to 0.
  - In-flight vectors are discarded and `m_valid` = 0 from the next cycle.
  - `s_ready` = 1 during and after reset.
- Arithmetic is unsigned, full `DATA_WIDTH`. There is no saturation or width growth.

## Timing
- Latency: `NUM_INPUTS` cycles from the accepting edge to `m_valid` high, in the absence of stalls (5 for the defaults).
- Throughput: one vector per cycle while `m_ready` = 1.
- `m_data`, `m_median`, `m_index` and `m_valid` are registers and carry no combinational path from inputs.
- `s_ready` is combinational from `m_ready` and `m_valid` only.
- A stall lasting k cycles adds exactly k cycles to the latency of every vector in flight.
- When `s_valid` is high during a stall, nothing is captured. The source holds the vector until `s_ready` = 1.
- Reset values: all outputs 0, except `s_ready` = 1.

## Configuration
- `SORT_INDEX_TRACK_EN`
  - Defined: each element carries a `$clog2(NUM_INPUTS)`-bit tag initialised to its input position k. Tags move with their data through every swap and are exposed on `m_index`.
  - Undefined: no tag registers and no `m_index` port. Data behaviour is identical.

## Structure
- Package `sort_pkg` holds:
  - the `NUM_INPUTS` legal-range constants;
  - the `sort_dir_t` enum (`SORT_ASC`, `SORT_DESC`);
  - a function that returns the compare-pair start offset for stage s.
- Sub-module `cmp_exchange_cell` is a combinational min/max with direction input and optional tag pass-through. It is instantiated per pair per stage.
- Stage registers, valid/direction pipeline and stall logic live in the top level.

## Test plan
- Reset held 3 cycles with `s_valid` = 1 → `m_valid` = 0, `m_data` = 0, `m_median` = 0, `s_ready` = 1 throughout; nothing emitted after release.
- N=5, W=8, ascending {10,5,255,100,180}, `m_ready` = 1 → exactly 5 cycles later `m_data` = {5,10,100,180,255}, `m_median` = 100.
- Same vector with `s_descending` = 1, issued the cycle after an ascending vector → outputs on consecutive cycles: {5,10,100,180,255}, then {255,180,100,10,5} with median 100.
- Ties {180,180,7,7,0}, ascending, `SORT_INDEX_TRACK_EN` defined → `m_data` = {0,7,7,180,180}, `m_index` = {4,2,3,0,1} (stable).
- Three back-to-back vectors; `m_ready` low for 2 cycles while the first is at the output:
  - `s_ready` is low for those 2 cycles;
  - the first vector is held stable;
  - all three vectors are emitted in order with no loss or duplication.
- Reset asserted for 1 cycle with 3 vectors in flight → `m_valid` = 0 the following cycle and no stale vector appears afterwards; a new vector accepted after release emerges after 5 cycles, correctly sorted.
